// File: rtl/ex_pkg.sv
// ex_pkg: shared constants for the execute stage of the 16-bit, 4-register datapath.
//   - DEF_DATA_W : default datapath width
//   - REG_ZERO   : index of the hardwired-zero register
//   - OP_*       : ALU opcodes
//   - ST_*       : execute-stage state encodings
package ex_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam logic [1:0]  REG_ZERO   = 2'd0;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND = 3'b000;
  localparam op_t OP_OR  = 3'b001;
  localparam op_t OP_ADD = 3'b010;
  localparam op_t OP_MUL = 3'b011;
  localparam op_t OP_NOR = 3'b100;
  localparam op_t OP_RSV = 3'b101;
  localparam op_t OP_SUB = 3'b110;
  localparam op_t OP_SLT = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: iterative shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_start        : latch i_a (multiplicand) and i_b (multiplier), clear acc/counter
//   i_hold         : on the final iteration, freeze instead of completing
//   o_done         : final iteration is in progress this cycle
//   o_product      : low DATA_W bits of the product, valid while o_done
module mul_shift_add import ex_pkg::*; #(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MUL_CYCLES = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_hold,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_done,
  output logic [DATA_W-1:0] o_product
);

  localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic              r_busy;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_acc_next;
  logic              w_step;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done     = r_busy && (r_cnt == CNT_W'(MUL_CYCLES - 1));
  // The final partial product is folded in combinationally so the result is
  // available on the same edge that retires the last iteration.
  assign o_product  = w_acc_next;
  assign w_step     = r_busy && !(o_done && i_hold);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Performs the ALU op on (a, b) and registers the
// write-back triple (wd, wr, regwrite) behind a valid/ready handshake.
// Ports:
//   clock, reset_n        : clock, async active-low reset
//   in_valid/in_ready     : input handshake for op, a, b, dst, wen
//   out_valid/out_ready   : output handshake for wd, wr, regwrite
//   zero                  : wd == 0, from the output register
// Build option: define EX_STAGE_MUL_EN to enable the 16-cycle shift-add MUL.
// Without it, opcode 011 returns 0 in one cycle like the reserved opcode.
module ex_stage import ex_pkg::*; #(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MUL_CYCLES = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        dst,
  input  logic              wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wd,
  output logic [1:0]        wr,
  output logic              regwrite,
  output logic              zero
);

  if (MUL_CYCLES != DATA_W) begin : g_param_check
    $error("ex_stage: MUL_CYCLES must equal DATA_W");
  end

  logic [0:0]        r_state;
  logic [0:0]        w_state_d;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_wd;
  logic [1:0]        r_wr;
  logic              r_regwrite;

  logic              w_free;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_mul_load;
  logic [DATA_W-1:0] w_mul_product;
  logic [1:0]        w_mul_dst;
  logic              w_mul_wen;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_load;
  logic [DATA_W-1:0] w_ld_wd;
  logic [1:0]        w_ld_wr;
  logic              w_ld_wen;

  assign w_free   = !r_out_valid || out_ready;
  assign in_ready = (r_state == ST_IDLE) && w_free;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_alu_res = '0;
    case (op)
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      OP_ADD:  w_alu_res = a + b;
      OP_NOR:  w_alu_res = ~(a | b);
      OP_SUB:  w_alu_res = a + ~b + {{(DATA_W-1){1'b0}}, 1'b1};
      OP_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: w_alu_res = '0;  // reserved, and MUL when not built in
    endcase
  end

`ifdef EX_STAGE_MUL_EN
  logic       w_mul_done;
  logic [1:0] r_mul_dst;
  logic       r_mul_wen;

  assign w_is_mul = (op == OP_MUL);

  mul_shift_add #(
    .DATA_W     (DATA_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .i_clk     (clock),
    .i_rst_n   (reset_n),
    .i_start   (w_accept && w_is_mul),
    .i_hold    (!w_free),
    .i_a       (a),
    .i_b       (b),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  assign w_mul_load = (r_state == ST_MUL) && w_mul_done && w_free;
  assign w_mul_dst  = r_mul_dst;
  assign w_mul_wen  = r_mul_wen;

  always_comb begin
    w_state_d = r_state;
    if (r_state == ST_IDLE) begin
      if (w_accept && w_is_mul) w_state_d = ST_MUL;
    end else if (w_mul_load) begin
      w_state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mul_dst <= '0;
      r_mul_wen <= 1'b0;
    end else if (w_accept && w_is_mul) begin
      r_mul_dst <= dst;
      r_mul_wen <= wen;
    end
  end
`else
  assign w_is_mul      = 1'b0;
  assign w_mul_load    = 1'b0;
  assign w_mul_product = '0;
  assign w_mul_dst     = '0;
  assign w_mul_wen     = 1'b0;
  assign w_state_d     = ST_IDLE;
`endif

  assign w_load   = (w_accept && !w_is_mul) || w_mul_load;
  assign w_ld_wd  = w_mul_load ? w_mul_product : w_alu_res;
  assign w_ld_wr  = w_mul_load ? w_mul_dst : dst;
  assign w_ld_wen = w_mul_load ? w_mul_wen : wen;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_wd        <= '0;
      r_wr        <= '0;
      r_regwrite  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_wd        <= w_ld_wd;
        r_wr        <= w_ld_wr;
        // Register 0 is hardwired to zero, so writes to it are dropped here.
        r_regwrite  <= w_ld_wen && (w_ld_wr != REG_ZERO);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign wd        = r_wd;
  assign wr        = r_wr;
  assign regwrite  = r_regwrite;
  assign zero      = (r_wd == '0);

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit, 4-register MIPS datapath. It sits directly downstream of `reg_file`: it consumes the two read ports (`rd1`, `rd2`) plus decoded control, performs the ALU operation, and produces the registered write-back triple (`wd`, `wr`, `regwrite`) that drives the register file's write port. A valid/ready handshake on both sides lets an optional multi-cycle multiplier stall the front end.

## Interface
Parameters:
- `DATA_W`, 16: datapath width. Must match the register file.
- `MUL_CYCLES`, 16: multiplier iterations. Must equal `DATA_W`.

Ports:
- `clock`  in  1: single clock. All state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operand/control bundle valid.
- `in_ready`  out  1: stage can accept a bundle this cycle.
- `op`  in  3: ALU control. 000 AND, 001 OR, 010 ADD, 011 MUL, 100 NOR, 101 reserved, 110 SUB, 111 SLT.
- `a`  in  DATA_W: operand A, from `rd1`.
- `b`  in  DATA_W: operand B, from `rd2` or the immediate.
- `dst`  in  2: destination register index.
- `wen`  in  1: instruction writes a register.
- `out_valid`  out  1: result bundle valid.
- `out_ready`  in  1: write-back consumer accepts the bundle.
- `wd`  out  DATA_W: result, driving the register-file write data.
- `wr`  out  2: destination index, driving the register-file write address.
- `regwrite`  out  1: write enable. Forced to 0 when `dst`==0, because register 0 is hardwired to zero.
- `zero`  out  1: `wd`==0. Combinational from the output register.

## Operation
- Acceptance occurs when `in_valid && in_ready`.
- `in_ready` = (state==IDLE) && (!`out_valid` || `out_ready`).
- Arithmetic:
  - All arithmetic wraps modulo 2^DATA_W. There is no overflow flag and no trap.
  - SUB computes a + ~b + 1.
  - SLT is a signed comparison. Result is 16'h0001 or 16'h0000.
  - MUL returns the low DATA_W bits of the unsigned product.
  - The reserved opcode 101 returns 0, with `regwrite` as for any op.
- State machine:
  - IDLE:
    - Non-MUL accept: load the output register and stay in IDLE.
    - MUL accept: latch a, b, dst and wen; clear the accumulator and counter; go to MUL.
  - MUL:
    - Each cycle: if multiplier bit 0 is set, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
    - When count==MUL_CYCLES-1: load the output register with the accumulator and go to IDLE.
    - Transition to IDLE also requires that the output register is free, i.e. !`out_valid` || `out_ready`. Otherwise stay in MUL, hold the accumulator and stop counting.
- Output register:
  - Holds `wd`/`wr`/`regwrite` stable while `out_valid && !out_ready`.
  - Clears `out_valid` on `out_ready` when no new result is loading the same cycle.
  - A simultaneous drain and load updates the contents and keeps `out_valid`=1.
- Reset mid-operation: an in-flight MUL is abandoned and nothing is emitted.
- Reset values:
  - `out_valid`=0, `wd`=0, `wr`=0, `regwrite`=0.
  - `zero`=1.
  - `in_ready`=1 after reset is released.
  - state=IDLE, counter=0, accumulator=0.

## Timing
- Non-MUL ops:
  - Latency 1: a bundle accepted at edge N appears with `out_valid`=1 after edge N.
  - Throughput 1 per cycle while `out_ready`=1.
- MUL:
  - Accepted at edge N; result valid after edge N+MUL_CYCLES (16 cycles).
  - `in_ready`=0 for the whole MUL state.
- Back-pressure: `out_ready`=0 with `out_valid`=1 drops `in_ready` in the same cycle, combinationally.
- The register file samples `regwrite`/`wd`/`wr` on the edge where `out_valid && out_ready`.

## Configuration
- `EX_STAGE_MUL_EN`:
  - Defined: the MUL state, the shift-add datapath and opcode 011 behave as above.
  - Undefined: the MUL state and multiplier logic are not compiled. Opcode 011 executes in 1 cycle like the reserved opcode: result 0, `regwrite` per `wen`/`dst`.

## Structure
- Shared package `ex_pkg`:
  - Opcode constants `OP_AND` … `OP_SLT` and the state enum (IDLE, MUL).
  - `DATA_W` default and the `REG_ZERO` index constant.
- One sub-module, `mul_shift_add`:
  - Iterative multiplier holding its own multiplicand, multiplier, accumulator and counter.
  - Has start/hold/done signals; instantiated only under `EX_STAGE_MUL_EN`.
- The ALU core is combinational inside `ex_stage`.

## Test plan
- Reset check: assert `reset_n`=0 mid-run → `out_valid`=0, `wd`=0, `regwrite`=0, `zero`=1, `in_ready`=1 after release.
- Arithmetic wrap: ADD a=16'hFFFF, b=16'h0001, dst=1, wen=1 → next cycle `wd`=0, `zero`=1, `regwrite`=1, `wr`=1.
- SUB and SLT:
  - SUB a=5, b=7 → `wd`=16'hFFFE.
  - SLT a=16'hFFFF (−1), b=1 → `wd`=1.
- Register-0 suppression: OR a=3, b=4, dst=0, wen=1 → `wd`=7, `regwrite`=0.
- Multiply with back-pressure: MUL a=300, b=300 with `out_ready`=0 → `in_ready`=0 throughout. Once `out_ready` rises, `wd`=16'h5F90 (90000 mod 65536), emitted no earlier than 16 cycles after acceptance. Without the macro, the same op gives `wd`=0 after 1 cycle.
- Streaming: back-to-back ADDs with `out_ready` toggling 1/0 → no bundle lost or duplicated, and `wd` is held stable while stalled.
